dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
Write-side buffer between the single-cycle ARM core's data-memory port and the backing data memory. Core stores (MemWrite, ALUResult address, WriteData) are queued into a small FIFO and drained to memory through a valid/ready handshake, so a slow memory never lengthens the core's cycle. Loads read memory combinationally, and the block forwards the youngest matching buffered store onto ReadData. The core is stalled only when a store arrives while the buffer is full.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
AW, 32, address width
DW, 32, data width (word stores only)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  core store request this cycle
Addr  input  AW  store/load address from the core (ALUResult)
WriteData  input  DW  store data from the core
ReadData  output  DW  load data to the core, with forwarding applied
Stall  output  1  core must hold its PC and instruction this cycle
Empty  output  1  no buffered stores
Count  output  log2(DEPTH)+1  number of occupied entries
mem_rdaddr  output  AW  load address to memory; equals Addr
mem_rddata  input  DW  combinational read data from memory
mem_wvalid  output  1  head entry presented for write
mem_waddr  output  AW  head entry address
mem_wdata  output  DW  head entry data
mem_wready  input  1  memory accepts the head entry this cycle

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data, valid}.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is tracked explicitly: full when Count==DEPTH, empty when Count==0.
- Reset (asynchronous, takes effect immediately):
  - Pointers, Count and all valid bits clear; Empty=1, mem_wvalid=0.
  - Entry storage clears, so mem_waddr=0 and mem_wdata=0.
  - Stall=0 unless MemWrite is high while full, which cannot occur after reset.
  - Reset during operation discards pending stores without writing them.
- Enqueue: on the clk rising edge when MemWrite=1 and the buffer is not full, write {Addr, WriteData} at tail and advance tail.
  - A store into an empty buffer appears on mem_wvalid in the next cycle, giving one cycle of latency.
- Stall: combinational, Stall = MemWrite & full.
  - A same-cycle dequeue does not free a slot for that cycle's store; the store is accepted in the following cycle.
- Dequeue: on the rising edge when mem_wvalid & mem_wready, clear the head entry and advance head.
  - mem_wvalid = (Count != 0).
  - mem_waddr and mem_wdata come from the head entry and must hold stable while mem_wvalid & !mem_wready.
- Simultaneous enqueue and dequeue: Count unchanged, both pointers advance.
- Ordering: memory writes are strictly in program order; there is no coalescing.
- Forwarding: compare Addr[AW-1:2] against every valid entry's addr[AW-1:2].
  - Address bits [1:0] are ignored in the compare.
  - On any hit, ReadData is the youngest matching entry, meaning the one nearest tail, with wrap handled.
  - With no hit, ReadData = mem_rddata.
  - The head entry being drained this cycle still forwards.
  - A store being enqueued this cycle is not forwarded.
- Empty = (Count==0), derived from registered state.
- No combinational path from mem_wready to Stall, mem_wvalid, mem_waddr or mem_wdata.

Test Plan:
- Reset: assert reset mid-cycle -> immediately Empty=1, Count=0, mem_wvalid=0, mem_waddr=0; Stall=0.
- Single store with mem_wready=0: MemWrite=1, Addr=0x40, WriteData=0xDEADBEEF -> next cycle mem_wvalid=1, mem_waddr=0x40, mem_wdata=0xDEADBEEF, Count=1.
  - Load Addr=0x42 with mem_rddata=0 -> ReadData=0xDEADBEEF.
  - Load Addr=0x44 with mem_rddata=0x5 -> ReadData=0x5.
- Youngest wins: store 0x1 then 0x2 to 0x40 with mem_wready=0 -> load 0x40 gives ReadData=0x2.
  - Then raise mem_wready -> memory sees 0x1 then 0x2 at 0x40, and Empty=1 after 2 cycles.
- Full/stall: 4 stores with mem_wready=0, then a 5th with MemWrite=1, Addr=0x50, WriteData=0x55 -> Stall=1, Count=4, mem_waddr unchanged.
  - Pulse mem_wready for 1 cycle -> Count=3, Stall=0 next cycle, the 5th store is accepted, Count=4.
- Simultaneous enqueue/dequeue at Count=2 with mem_wready=1 and MemWrite=1 -> Count stays 2.
  - Over 8 such cycles the tail wraps, and drain order matches issue order.
- Reset with Count=3 and mem_wvalid=1 -> Count=0 and mem_wvalid=0 immediately; the dropped entries are never written to memory.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - Core-side store FIFO with in-order memory drain and youngest-store load forwarding.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            Addr,
    input  logic [DW-1:0]            WriteData,
    output logic [DW-1:0]            ReadData,
    output logic                     Stall,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [AW-1:0]            mem_rdaddr,
    input  logic [DW-1:0]            mem_rddata,
    output logic                     mem_wvalid,
    output logic [AW-1:0]            mem_waddr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_wready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [PW-1:0]    fwd_idx;
    logic             full;
    logic             enq;
    logic             deq;

    assign full       = (count_q == CW'(DEPTH));
    assign enq        = MemWrite & ~full;
    assign deq        = (count_q != '0) & mem_wready;
    assign Stall      = MemWrite & full;
    assign Empty      = (count_q == '0);
    assign Count      = count_q;
    assign mem_rdaddr = Addr;
    assign mem_wvalid = (count_q != '0);
    assign mem_waddr  = addr_q[head_q];
    assign mem_wdata  = data_q[head_q];

    // Walk oldest to youngest so the last hit (nearest tail) wins.
    always_comb begin
        ReadData = mem_rddata;
        fwd_idx  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if (valid_q[fwd_idx] && (addr_q[fwd_idx][AW-1:2] == Addr[AW-1:2])) begin
                ReadData = data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    // Enqueue and dequeue never target the same slot: that needs both empty and full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                addr_q[tail_q]  <= Addr;
                data_q[tail_q]  <= WriteData;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PW'(1);
            end
            if (deq) begin
                addr_q[head_q]  <= '0;
                data_q[head_q]  <= '0;
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PW'(1);
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - Randomized and directed self-checking bench against a queue-based store buffer model.
module tb_dmem_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic [2:0]  Count;
    logic [31:0] mem_rdaddr;
    logic [31:0] mem_rddata;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;

    int errors = 0;
    int checks = 0;

    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic [31:0] memm [8];

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .Empty(Empty), .Count(Count), .mem_rdaddr(mem_rdaddr),
        .mem_rddata(mem_rddata), .mem_wvalid(mem_wvalid),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wready(mem_wready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rd);
        for (int i = qa.size() - 1; i >= 0; i--) begin
            if (qa[i][31:2] == a[31:2]) return qd[i];
        end
        return rd;
    endfunction

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                         input logic wr, input logic [31:0] rd);
        @(negedge clk);
        MemWrite = mw; Addr = a; WriteData = wd; mem_wready = wr; mem_rddata = rd;
        #1;
        chk("ReadData", ReadData, model_read(a, rd));
        chk("Stall", 32'(Stall), 32'(mw && qa.size() == DEPTH));
        chk("Count", 32'(Count), 32'(qa.size()));
        chk("Empty", 32'(Empty), 32'(qa.size() == 0));
        chk("mem_wvalid", 32'(mem_wvalid), 32'(qa.size() != 0));
        chk("mem_waddr", mem_waddr, qa.size() != 0 ? qa[0] : 32'h0);
        chk("mem_wdata", mem_wdata, qd.size() != 0 ? qd[0] : 32'h0);
        chk("mem_rdaddr", mem_rdaddr, a);
    endtask

    task automatic tick();
        bit do_enq;
        bit do_deq;
        @(posedge clk);
        do_enq = MemWrite && qa.size() < DEPTH;
        do_deq = qa.size() != 0 && mem_wready;
        if (do_deq) begin
            memm[qa[0][4:2]] = qd[0];
            void'(qa.pop_front());
            void'(qd.pop_front());
        end
        if (do_enq) begin
            qa.push_back(Addr);
            qd.push_back(WriteData);
        end
    endtask

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                        input logic wr, input logic [31:0] rd);
        drive(mw, a, wd, wr, rd);
        tick();
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        mem_wready = 1'b0; mem_rddata = '0;
        for (int i = 0; i < 8; i++) memm[i] = '0;
        @(negedge clk); #1;
        chk("rst_Count", 32'(Count), 0);
        chk("rst_Empty", 32'(Empty), 1);
        chk("rst_wvalid", 32'(mem_wvalid), 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_Stall", 32'(Stall), 0);
        reset = 1'b0;

        // Single store then forwarding and miss
        step(1, 32'h40, 32'hDEADBEEF, 0, 0);
        drive(0, 32'h42, 0, 0, 0);
        chk("single_wvalid", 32'(mem_wvalid), 1);
        chk("single_waddr", mem_waddr, 32'h40);
        chk("single_wdata", mem_wdata, 32'hDEADBEEF);
        chk("single_Count", 32'(Count), 1);
        chk("fwd_hit", ReadData, 32'hDEADBEEF);
        tick();
        drive(0, 32'h44, 0, 0, 32'h5);
        chk("fwd_miss", ReadData, 32'h5);
        tick();
        step(0, 32'h0, 0, 1, 0);

        // Youngest wins, then in-order drain
        step(1, 32'h40, 32'h1, 0, 0);
        step(1, 32'h40, 32'h2, 0, 0);
        drive(0, 32'h40, 0, 0, 32'h77);
        chk("youngest", ReadData, 32'h2);
        tick();
        drive(0, 32'h0, 0, 1, 0);
        chk("drain0", mem_wdata, 32'h1);
        tick();
        drive(0, 32'h0, 0, 1, 0);
        chk("drain1", mem_wdata, 32'h2);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        chk("drained_Empty", 32'(Empty), 1);
        tick();

        // Full and stall
        for (int i = 0; i < 4; i++) step(1, 32'h10 + 32'(4 * i), 32'(i + 10), 0, 0);
        drive(1, 32'h50, 32'h55, 0, 0);
        chk("full_Stall", 32'(Stall), 1);
        chk("full_Count", 32'(Count), 4);
        chk("full_waddr", mem_waddr, 32'h10);
        tick();
        drive(1, 32'h50, 32'h55, 1, 0);
        chk("full_deq_Stall", 32'(Stall), 1);
        tick();
        drive(1, 32'h50, 32'h55, 0, 0);
        chk("after_pulse_Stall", 32'(Stall), 0);
        chk("after_pulse_Count", 32'(Count), 3);
        tick();
        drive(0, 32'h50, 0, 0, 0);
        chk("accepted_Count", 32'(Count), 4);
        chk("accepted_fwd", ReadData, 32'h55);
        tick();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Simultaneous enqueue/dequeue across tail wrap
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h60 + 32'(4 * (i % 4)), $urandom, 1, 0);
            chk("simul_Count", 32'(Count), 2);
            tick();
        end
        step(1, 32'h48, 32'hABCD, 0, 0);

        // Mid-cycle reset with pending stores
        drive(0, 0, 0, 0, 0);
        chk("pre_rst_Count", 32'(Count), 3);
        #2 reset = 1'b1;
        #1;
        chk("midrst_Count", 32'(Count), 0);
        chk("midrst_wvalid", 32'(mem_wvalid), 0);
        chk("midrst_Empty", 32'(Empty), 1);
        chk("midrst_waddr", mem_waddr, 0);
        chk("midrst_Stall", 32'(Stall), 0);
        qa.delete();
        qd.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 32'h48, 0, 1, 32'h9);

        // Randomized traffic over a small address window
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = 32'h40 + {27'd0, 3'($urandom_range(0, 7)), 2'b00} + 32'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 2) != 0), memm[a[4:2]]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
